ysyx_23060077_rd_arb: RTL and testbench

Read-channel arbiter and sequencer between the core's two read requesters (IFU fetch, LSU load) and the single AXI4 AR/R master channel. It grants one requester at a time with round-robin fairness, drives the AR handshake, steers R beats back to the granted requester, and tracks burst length and response errors. It sits between the IFU/LSU simple read ports and `io_master_ar*`/`io_master_r*`; the write channels are out of scope.

---
 rtl/ysyx_23060077_rd_arb_if.sv | 66 ++++++
 rtl/ysyx_23060077_rd_arb.sv | 151 +++++++++++++++
 tb/tb_ysyx_23060077_rd_arb.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060077_rd_arb_if.sv
// Read-arbiter port bundle: the IFU/LSU simple read ports on one side and the
// AXI4 AR/R master channel on the other. "master" is the arbiter's view,
// "slave" the view of whatever drives the requesters and the AXI slave.
interface ysyx_23060077_rd_arb_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 8
);
    // IFU read port
    logic                  ifu_r_valid_i;
    logic [ADDR_WIDTH-1:0] ifu_r_addr_i;
    logic [LEN_WIDTH-1:0]  ifu_r_len_i;
    logic                  ifu_r_ready_o;
    logic [DATA_WIDTH-1:0] ifu_r_data_o;
    logic                  ifu_r_last_o;
    // LSU read port
    logic                  lsu_r_valid_i;
    logic [ADDR_WIDTH-1:0] lsu_r_addr_i;
    logic [LEN_WIDTH-1:0]  lsu_r_len_i;
    logic                  lsu_r_ready_o;
    logic [DATA_WIDTH-1:0] lsu_r_data_o;
    logic                  lsu_r_last_o;
    // AXI AR channel
    logic                  axi_ar_ready_i;
    logic                  axi_ar_valid_o;
    logic [ADDR_WIDTH-1:0] axi_ar_addr_o;
    logic [3:0]            axi_ar_id_o;
    logic [LEN_WIDTH-1:0]  axi_ar_len_o;
    logic [2:0]            axi_ar_size_o;
    logic [1:0]            axi_ar_burst_o;
    // AXI R channel
    logic                  axi_r_ready_o;
    logic                  axi_r_valid_i;
    logic [1:0]            axi_r_resp_i;
    logic [DATA_WIDTH-1:0] axi_r_data_i;
    logic                  axi_r_last_i;
    logic [3:0]            axi_r_id_i;
    // Sticky protocol/response error
    logic                  err_o;

    modport master (
        input  ifu_r_valid_i, ifu_r_addr_i, ifu_r_len_i,
        output ifu_r_ready_o, ifu_r_data_o, ifu_r_last_o,
        input  lsu_r_valid_i, lsu_r_addr_i, lsu_r_len_i,
        output lsu_r_ready_o, lsu_r_data_o, lsu_r_last_o,
        input  axi_ar_ready_i,
        output axi_ar_valid_o, axi_ar_addr_o, axi_ar_id_o, axi_ar_len_o,
        output axi_ar_size_o, axi_ar_burst_o,
        output axi_r_ready_o,
        input  axi_r_valid_i, axi_r_resp_i, axi_r_data_i, axi_r_last_i, axi_r_id_i,
        output err_o
    );

    modport slave (
        output ifu_r_valid_i, ifu_r_addr_i, ifu_r_len_i,
        input  ifu_r_ready_o, ifu_r_data_o, ifu_r_last_o,
        output lsu_r_valid_i, lsu_r_addr_i, lsu_r_len_i,
        input  lsu_r_ready_o, lsu_r_data_o, lsu_r_last_o,
        output axi_ar_ready_i,
        input  axi_ar_valid_o, axi_ar_addr_o, axi_ar_id_o, axi_ar_len_o,
        input  axi_ar_size_o, axi_ar_burst_o,
        input  axi_r_ready_o,
        output axi_r_valid_i, axi_r_resp_i, axi_r_data_i, axi_r_last_i, axi_r_id_i,
        input  err_o
    );
endinterface

// File: rtl/ysyx_23060077_rd_arb.sv
// Read-channel arbiter: round-robin grant between IFU and LSU, AR handshake,
// R-beat steering to the granted requester, burst-length and error tracking.
// The module width parameters must match those of the connected interface.
module ysyx_23060077_rd_arb #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter logic [3:0]  IFU_ID     = 4'd0,
    parameter logic [3:0]  LSU_ID     = 4'd1
) (
    input  logic                   aclk,
    input  logic                   areset_n,
    ysyx_23060077_rd_arb_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2
    } state_t;

    state_t                state_q,    state_d;
    logic                  gnt_lsu_q,  gnt_lsu_d;   // 1: LSU owns the channel
    logic                  rr_lsu_q,   rr_lsu_d;    // 1: LSU wins the next tie
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [LEN_WIDTH-1:0]  len_q,      len_d;
    logic [3:0]            id_q,       id_d;
    logic [LEN_WIDTH-1:0]  cnt_q,      cnt_d;
    logic                  err_q,      err_d;
    logic                  ar_valid_q, ar_valid_d;
    logic                  r_ready_q,  r_ready_d;

    logic                  beat;
    logic                  pick_lsu;
    logic                  beat_err;
    logic                  ifu_hit;
    logic                  lsu_hit;
    logic [DATA_WIDTH-1:0] beat_data;

    // Beat qualification, tie-break choice and per-beat error detection
    always_comb begin
        beat      = (state_q == S_R) && bus.axi_r_valid_i;
        pick_lsu  = (bus.ifu_r_valid_i && bus.lsu_r_valid_i) ? rr_lsu_q : bus.lsu_r_valid_i;
        beat_err  = (bus.axi_r_resp_i != 2'b00)
                 || (bus.axi_r_id_i != id_q)
                 || ( bus.axi_r_last_i && (cnt_q != '0))
                 || (!bus.axi_r_last_i && (cnt_q == '0));
        ifu_hit   = beat && !gnt_lsu_q;
        lsu_hit   = beat &&  gnt_lsu_q;
        beat_data = bus.axi_r_data_i;
    end

    // Next-state and registered-output computation for the IDLE/AR/R sequencer
    always_comb begin
        state_d    = state_q;
        gnt_lsu_d  = gnt_lsu_q;
        rr_lsu_d   = rr_lsu_q;
        addr_d     = addr_q;
        len_d      = len_q;
        id_d       = id_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        ar_valid_d = ar_valid_q;
        r_ready_d  = r_ready_q;
        case (state_q)
            S_IDLE: begin
                if (bus.ifu_r_valid_i || bus.lsu_r_valid_i) begin
                    state_d    = S_AR;
                    ar_valid_d = 1'b1;
                    gnt_lsu_d  = pick_lsu;
                    addr_d     = pick_lsu ? bus.lsu_r_addr_i : bus.ifu_r_addr_i;
                    len_d      = pick_lsu ? bus.lsu_r_len_i  : bus.ifu_r_len_i;
                    id_d       = pick_lsu ? LSU_ID : IFU_ID;
                end
            end
            S_AR: begin
                if (bus.axi_ar_ready_i) begin
                    state_d    = S_R;
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    cnt_d      = len_q;
                end
            end
            S_R: begin
                if (bus.axi_r_valid_i) begin
                    if (beat_err) begin
                        err_d = 1'b1;
                    end
                    // Saturate so an overrun burst keeps reporting counter==0
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - LEN_WIDTH'(1);
                    end
                    if (bus.axi_r_last_i) begin
                        state_d   = S_IDLE;
                        r_ready_d = 1'b0;
                        rr_lsu_d  = !gnt_lsu_q;
                    end
                end
            end
            default: begin
                state_d    = S_IDLE;
                ar_valid_d = 1'b0;
                r_ready_d  = 1'b0;
            end
        endcase
    end

    // State and registered-output update with asynchronous active-low reset
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q    <= S_IDLE;
            gnt_lsu_q  <= 1'b0;
            rr_lsu_q   <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            id_q       <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_lsu_q  <= gnt_lsu_d;
            rr_lsu_q   <= rr_lsu_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            id_q       <= id_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            ar_valid_q <= ar_valid_d;
            r_ready_q  <= r_ready_d;
        end
    end

    assign bus.axi_ar_valid_o = ar_valid_q;
    assign bus.axi_ar_addr_o  = addr_q;
    assign bus.axi_ar_len_o   = len_q;
    assign bus.axi_ar_id_o    = id_q;
    assign bus.axi_ar_size_o  = ar_valid_q ? 3'b010 : 3'b000;
    assign bus.axi_ar_burst_o = ar_valid_q ? 2'b01  : 2'b00;
    assign bus.axi_r_ready_o  = r_ready_q;
    assign bus.err_o          = err_q;

    assign bus.ifu_r_ready_o  = ifu_hit;
    assign bus.ifu_r_last_o   = ifu_hit && bus.axi_r_last_i;
    assign bus.ifu_r_data_o   = ifu_hit ? beat_data : '0;
    assign bus.lsu_r_ready_o  = lsu_hit;
    assign bus.lsu_r_last_o   = lsu_hit && bus.axi_r_last_i;
    assign bus.lsu_r_data_o   = lsu_hit ? beat_data : '0;

endmodule

// File: tb/tb_ysyx_23060077_rd_arb.sv
// Directed bench for the IFU/LSU read arbiter.
module tb_ysyx_23060077_rd_arb;

    logic aclk;
    logic areset_n;
    int   checks;
    int   errors;

    ysyx_23060077_rd_arb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(8)) bus ();

    ysyx_23060077_rd_arb #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .LEN_WIDTH (8),
        .IFU_ID    (4'd0),
        .LSU_ID    (4'd1)
    ) dut (
        .aclk    (aclk),
        .areset_n(areset_n),
        .bus     (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.ifu_r_valid_i  = 1'b0;
        bus.ifu_r_addr_i   = '0;
        bus.ifu_r_len_i    = '0;
        bus.lsu_r_valid_i  = 1'b0;
        bus.lsu_r_addr_i   = '0;
        bus.lsu_r_len_i    = '0;
        bus.axi_ar_ready_i = 1'b0;
        bus.axi_r_valid_i  = 1'b0;
        bus.axi_r_resp_i   = '0;
        bus.axi_r_data_i   = '0;
        bus.axi_r_last_i   = 1'b0;
        bus.axi_r_id_i     = '0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_arv"},   bus.axi_ar_valid_o, 0);
        chk({tag, "_aradr"}, bus.axi_ar_addr_o,  0);
        chk({tag, "_arlen"}, bus.axi_ar_len_o,   0);
        chk({tag, "_arid"},  bus.axi_ar_id_o,    0);
        chk({tag, "_arsz"},  bus.axi_ar_size_o,  0);
        chk({tag, "_arbst"}, bus.axi_ar_burst_o, 0);
        chk({tag, "_rrdy"},  bus.axi_r_ready_o,  0);
        chk({tag, "_irdy"},  bus.ifu_r_ready_o,  0);
        chk({tag, "_idat"},  bus.ifu_r_data_o,   0);
        chk({tag, "_ilst"},  bus.ifu_r_last_o,   0);
        chk({tag, "_lrdy"},  bus.lsu_r_ready_o,  0);
        chk({tag, "_ldat"},  bus.lsu_r_data_o,   0);
        chk({tag, "_llst"},  bus.lsu_r_last_o,   0);
        chk({tag, "_err"},   bus.err_o,          0);
    endtask

    // Reset pulse; returns at a falling edge with reset released.
    task automatic do_reset();
        @(negedge aclk);
        areset_n = 1'b0;
        clear_inputs();
        @(negedge aclk);
        areset_n = 1'b1;
    endtask

    // Request already raised for one IDLE cycle: check AR, accept it, check r_ready.
    task automatic grant_ar(input string tag, input bit lsu, input logic [31:0] addr,
                            input logic [7:0] len);
        @(negedge aclk);
        #1;
        chk({tag, "_arv"},   bus.axi_ar_valid_o, 1);
        chk({tag, "_aradr"}, bus.axi_ar_addr_o,  addr);
        chk({tag, "_arlen"}, bus.axi_ar_len_o,   len);
        chk({tag, "_arid"},  bus.axi_ar_id_o,    lsu ? 4'd1 : 4'd0);
        chk({tag, "_arsz"},  bus.axi_ar_size_o,  3'b010);
        chk({tag, "_arbst"}, bus.axi_ar_burst_o, 2'b01);
        chk({tag, "_rrdy0"}, bus.axi_r_ready_o,  0);
        bus.axi_ar_ready_i = 1'b1;
        @(negedge aclk);
        bus.axi_ar_ready_i = 1'b0;
        #1;
        chk({tag, "_rrdy1"}, bus.axi_r_ready_o,  1);
        chk({tag, "_arv0"},  bus.axi_ar_valid_o, 0);
    endtask

    // One R beat presented now; checks steering, then removes it at the next falling edge.
    task automatic beat(input string tag, input bit lsu, input logic [31:0] d, input bit last,
                        input logic [1:0] resp, input logic [3:0] id);
        bus.axi_r_valid_i = 1'b1;
        bus.axi_r_data_i  = d;
        bus.axi_r_last_i  = last;
        bus.axi_r_resp_i  = resp;
        bus.axi_r_id_i    = id;
        #1;
        chk({tag, "_rdy"},  lsu ? bus.lsu_r_ready_o : bus.ifu_r_ready_o, 1);
        chk({tag, "_dat"},  lsu ? bus.lsu_r_data_o  : bus.ifu_r_data_o,  d);
        chk({tag, "_lst"},  lsu ? bus.lsu_r_last_o  : bus.ifu_r_last_o,  last);
        chk({tag, "_ordy"}, lsu ? bus.ifu_r_ready_o : bus.lsu_r_ready_o, 0);
        chk({tag, "_odat"}, lsu ? bus.ifu_r_data_o  : bus.lsu_r_data_o,  0);
        chk({tag, "_olst"}, lsu ? bus.ifu_r_last_o  : bus.lsu_r_last_o,  0);
        @(negedge aclk);
        bus.axi_r_valid_i = 1'b0;
        bus.axi_r_last_i  = 1'b0;
        bus.axi_r_resp_i  = 2'b00;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        areset_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge aclk);
        #1;
        chk_zero("rst");
        @(negedge aclk);
        areset_n = 1'b1;

        // IFU single beat
        @(negedge aclk);
        bus.ifu_r_valid_i = 1'b1;
        bus.ifu_r_addr_i  = 32'h3000_0000;
        bus.ifu_r_len_i   = 8'd0;
        #1;
        chk("t1_idle_arv", bus.axi_ar_valid_o, 0);
        grant_ar("t1", 1'b0, 32'h3000_0000, 8'd0);
        beat("t1_b", 1'b0, 32'hDEAD_BEEF, 1'b1, 2'b00, 4'd0);
        bus.ifu_r_valid_i = 1'b0;
        #1;
        chk("t1_rrdy_end", bus.axi_r_ready_o, 0);
        chk("t1_err", bus.err_o, 0);

        // Both valid after reset: IFU, LSU, IFU, LSU
        do_reset();
        bus.ifu_r_valid_i = 1'b1;
        bus.ifu_r_addr_i  = 32'h0000_0100;
        bus.ifu_r_len_i   = 8'd0;
        bus.lsu_r_valid_i = 1'b1;
        bus.lsu_r_addr_i  = 32'h0000_0200;
        bus.lsu_r_len_i   = 8'd0;
        for (int i = 0; i < 4; i++) begin
            bit exp_lsu;
            exp_lsu = (i % 2) == 1;
            #1;
            chk($sformatf("rr%0d_idle", i), bus.axi_ar_valid_o, 0);
            grant_ar($sformatf("rr%0d", i), exp_lsu,
                     exp_lsu ? 32'h0000_0200 : 32'h0000_0100, 8'd0);
            beat($sformatf("rr%0d_b", i), exp_lsu, 32'h0000_00A0 + i, 1'b1, 2'b00,
                 exp_lsu ? 4'd1 : 4'd0);
        end
        bus.ifu_r_valid_i = 1'b0;
        bus.lsu_r_valid_i = 1'b0;

        // LSU len 3, AR stalled 5 cycles, gap between beats 2 and 3
        @(negedge aclk);
        bus.lsu_r_valid_i = 1'b1;
        bus.lsu_r_addr_i  = 32'h8000_0040;
        bus.lsu_r_len_i   = 8'd3;
        #1;
        chk("t3_idle_arv", bus.axi_ar_valid_o, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            #1;
            chk($sformatf("t3_stall%0d_arv", i),  bus.axi_ar_valid_o, 1);
            chk($sformatf("t3_stall%0d_adr", i),  bus.axi_ar_addr_o,  32'h8000_0040);
            chk($sformatf("t3_stall%0d_len", i),  bus.axi_ar_len_o,   8'd3);
            chk($sformatf("t3_stall%0d_id", i),   bus.axi_ar_id_o,    4'd1);
            chk($sformatf("t3_stall%0d_rrdy", i), bus.axi_r_ready_o,  0);
        end
        @(negedge aclk);
        bus.axi_ar_ready_i = 1'b1;
        #1;
        chk("t3_hs_arv", bus.axi_ar_valid_o, 1);
        @(negedge aclk);
        bus.axi_ar_ready_i = 1'b0;
        #1;
        chk("t3_rrdy", bus.axi_r_ready_o, 1);
        beat("t3_b1", 1'b1, 32'h0000_0001, 1'b0, 2'b00, 4'd1);
        beat("t3_b2", 1'b1, 32'h0000_0002, 1'b0, 2'b00, 4'd1);
        #1;
        chk("t3_gap_lrdy", bus.lsu_r_ready_o, 0);
        chk("t3_gap_rrdy", bus.axi_r_ready_o, 1);
        @(negedge aclk);
        beat("t3_b3", 1'b1, 32'h0000_0003, 1'b0, 2'b00, 4'd1);
        beat("t3_b4", 1'b1, 32'h0000_0004, 1'b1, 2'b00, 4'd1);
        bus.lsu_r_valid_i = 1'b0;
        #1;
        chk("t3_err", bus.err_o, 0);
        chk("t3_end_rrdy", bus.axi_r_ready_o, 0);

        // Error: bad response code
        do_reset();
        bus.ifu_r_valid_i = 1'b1;
        bus.ifu_r_addr_i  = 32'h0000_1000;
        bus.ifu_r_len_i   = 8'd0;
        grant_ar("e1", 1'b0, 32'h0000_1000, 8'd0);
        beat("e1_b", 1'b0, 32'h1111_1111, 1'b1, 2'b10, 4'd0);
        bus.ifu_r_valid_i = 1'b0;
        #1;
        chk("e1_err", bus.err_o, 1);
        repeat (2) @(negedge aclk);
        #1;
        chk("e1_sticky", bus.err_o, 1);

        // Error: wrong response ID
        do_reset();
        #1;
        chk("e2_err_clr", bus.err_o, 0);
        bus.ifu_r_valid_i = 1'b1;
        bus.ifu_r_addr_i  = 32'h0000_2000;
        bus.ifu_r_len_i   = 8'd0;
        grant_ar("e2", 1'b0, 32'h0000_2000, 8'd0);
        beat("e2_b", 1'b0, 32'h2222_2222, 1'b1, 2'b00, 4'd5);
        bus.ifu_r_valid_i = 1'b0;
        #1;
        chk("e2_err", bus.err_o, 1);

        // Error: early last on beat 2 of a len-3 burst
        do_reset();
        bus.ifu_r_valid_i = 1'b1;
        bus.ifu_r_addr_i  = 32'h0000_3000;
        bus.ifu_r_len_i   = 8'd3;
        grant_ar("e3", 1'b0, 32'h0000_3000, 8'd3);
        beat("e3_b1", 1'b0, 32'h3333_0001, 1'b0, 2'b00, 4'd0);
        #1;
        chk("e3_err_b1", bus.err_o, 0);
        beat("e3_b2", 1'b0, 32'h3333_0002, 1'b1, 2'b00, 4'd0);
        bus.ifu_r_valid_i = 1'b0;
        #1;
        chk("e3_err", bus.err_o, 1);
        chk("e3_idle_rrdy", bus.axi_r_ready_o, 0);
        @(negedge aclk);
        #1;
        chk("e3_idle_arv", bus.axi_ar_valid_o, 0);

        // Reset during beat 2 of an LSU burst, then a fresh IFU request
        do_reset();
        bus.lsu_r_valid_i = 1'b1;
        bus.lsu_r_addr_i  = 32'h8000_0080;
        bus.lsu_r_len_i   = 8'd3;
        grant_ar("r5", 1'b1, 32'h8000_0080, 8'd3);
        beat("r5_b1", 1'b1, 32'h4444_0001, 1'b0, 2'b00, 4'd1);
        bus.axi_r_valid_i = 1'b1;
        bus.axi_r_data_i  = 32'h4444_0002;
        bus.axi_r_id_i    = 4'd1;
        #1;
        chk("r5_b2_lrdy", bus.lsu_r_ready_o, 1);
        areset_n = 1'b0;
        #1;
        chk_zero("r5_async");
        bus.axi_r_valid_i = 1'b0;
        bus.lsu_r_valid_i = 1'b0;
        @(negedge aclk);
        areset_n = 1'b1;
        bus.ifu_r_valid_i = 1'b1;
        bus.ifu_r_addr_i  = 32'h3000_0000;
        bus.ifu_r_len_i   = 8'd0;
        #1;
        chk("r5_idle_arv", bus.axi_ar_valid_o, 0);
        grant_ar("r5_new", 1'b0, 32'h3000_0000, 8'd0);
        beat("r5_new_b", 1'b0, 32'hCAFE_F00D, 1'b1, 2'b00, 4'd0);
        bus.ifu_r_valid_i = 1'b0;
        #1;
        chk("r5_err", bus.err_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
